// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: rotating-priority arbiter that holds a registered one-hot grant per owner.
// Latency: a request sampled at edge N is granted after edge N; a release hands over at that same edge.
// Backpressure: non-owners wait and never preempt; the owner keeps the grant until release or MAX_HOLD cycles.
module rr_grant_arbiter #(
  parameter int REQ_NUM  = 7,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [REQ_NUM-1:0]         req_i,
  output logic [REQ_NUM-1:0]         gnt_o,
  output logic                       gnt_val_o,
  output logic [$clog2(REQ_NUM)-1:0] gnt_id_o,
  output logic                       timeout_o
);

  localparam int IW = $clog2(REQ_NUM);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REQ_NUM-1:0]  gnt_q, gnt_d;
  logic                val_q, val_d;
  logic [IW-1:0]       id_q, id_d;
  logic                to_q, to_d;

  logic [REQ_NUM-1:0]  cand;
  logic [IW-1:0]       start;
  logic [IW-1:0]       nxt_ptr;
  logic                rel, tmo;
  logic                pick_vld;
  logic [IW-1:0]       pick_id;
  int                  idx;

  // Candidate set, search start and the rotating first-set search.
  // On a handover the current owner is masked out and the search starts just past it,
  // which is exactly where the pointer is being moved to at this edge.
  always_comb begin
    nxt_ptr = (id_q == IW'(REQ_NUM - 1)) ? '0 : id_q + 1'b1;
    rel     = ~req_i[id_q];
    tmo     = (cnt_q == CW'(MAX_HOLD));
    cand    = req_i;
    start   = ptr_q;
    if (state_q == GRANT) begin
      cand[id_q] = 1'b0;
      start      = nxt_ptr;
    end
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    // Walk offsets from the far end so the nearest set bit at/after start wins.
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (cand[idx[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = idx[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic; release takes precedence over timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    val_d   = val_q;
    id_d    = id_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          val_d          = 1'b1;
          id_d           = pick_id;
          cnt_d          = CW'(1);
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (rel || tmo) begin
          ptr_d = nxt_ptr;
          to_d  = ~rel;
          if (pick_vld) begin
            gnt_d          = '0;
            gnt_d[pick_id] = 1'b1;
            id_d           = pick_id;
            cnt_d          = CW'(1);
          end else begin
            gnt_d   = '0;
            val_d   = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared immediately on reset assertion.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      val_q   <= 1'b0;
      id_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      val_q   <= val_d;
      id_q    <= id_d;
      to_q    <= to_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_val_o = val_q;
  assign gnt_id_o  = id_q;
  assign timeout_o = to_q;

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one priority-encoded datapath resource between REQ_NUM requesters. It resolves simultaneous requests with a rotating-priority, lowest-index-first search, then holds a registered one-hot grant until the owner releases or a hold limit expires. It sits in front of the encoder/deserialiser datapath and drives its input selection.

## Interface
- REQ_NUM, 7, number of requesters (2..32)
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant (2..255)
- clk_i  input  1  single clock; all logic on the rising edge
- arstn_i  input  1  asynchronous, active-low reset; assertion is immediate and needs no clock; deassertion is synchronised externally
- req_i  input  REQ_NUM  per-requester request level; bit i high = requester i wants or keeps the resource
- gnt_o  output  REQ_NUM  registered one-hot grant; all-zero when no owner
- gnt_val_o  output  1  high when gnt_o has a bit set
- gnt_id_o  output  $clog2(REQ_NUM)  binary index of the owner; holds the last owner when gnt_val_o is low
- timeout_o  output  1  one-cycle pulse: the grant was revoked by the MAX_HOLD limit

## Operation
- State machine IDLE / GRANT; internal rotate pointer ptr in 0..REQ_NUM-1; hold counter hold_cnt of width $clog2(MAX_HOLD+1).
- Arbitration function pick(mask_bit):
  - cand = req_i with bit mask_bit cleared (no bit cleared when called from IDLE).
  - First search for the lowest set index >= ptr in cand.
  - If there is none, search for the lowest set index in cand (wrap-around).
  - If there is still none, no grant.
- IDLE, any req_i set:
  - Grant pick() at the next edge; set gnt_o, gnt_val_o and gnt_id_o.
  - hold_cnt <= 1; go to GRANT.
- IDLE, no request: outputs stay deasserted.
- GRANT, end condition sampled at an edge: req_i[gnt_id_o]==0 (release) or hold_cnt==MAX_HOLD (timeout).
- GRANT, no end condition: hold_cnt increments; all outputs hold.
- GRANT, end condition true:
  - ptr <= (gnt_id_o+1) mod REQ_NUM.
  - The next owner is pick(gnt_id_o), using the updated ptr. The current owner is always excluded, so a timed-out owner cannot immediately re-win.
  - If a new owner exists: switch gnt_o directly to it in the same edge (zero-gap handover); hold_cnt <= 1; stay in GRANT.
  - If none: gnt_o <= 0, gnt_val_o <= 0, go to IDLE.
- timeout_o is 1 for exactly the cycle after an edge that ended a grant by timeout. It is 0 after a release.
- Requests from non-owners never preempt the current owner.
- Requests that appear and vanish between edges are not seen.

## Timing
- Reset values: gnt_o=0, gnt_val_o=0, gnt_id_o=0, timeout_o=0, ptr=0, hold_cnt=0, state IDLE.
- Reset asserted mid-grant clears all outputs asynchronously. After reset the first grant again starts the search from index 0.
- Latency from request to grant: request seen at edge N means grant visible after edge N (1 cycle).
- Release latency: owner's req_i low sampled at edge N means gnt_o changes at edge N.
- Maximum tenure: exactly MAX_HOLD consecutive cycles with gnt_o asserted.
- Simultaneous release and timeout on the same edge count as a release (timeout_o=0).
- Handover never produces a cycle with two grant bits set. gnt_o is always one-hot or zero.
- Starvation bound: a continuously asserted request is granted within (REQ_NUM-1)*MAX_HOLD cycles plus REQ_NUM handover edges.

## Test plan
- Reset, then req_i=7'b0100100 at edge 1 -> after edge 1: gnt_o=7'b0000100, gnt_id_o=2, gnt_val_o=1.
- Owner 2 drops its request while bit 5 is held -> at that same edge gnt_o=7'b0100000 with no idle gap; ptr becomes 3 at that edge, and the handover picks owner 5, the next requester at or above 3.
- MAX_HOLD=4, only req_i[0] held high -> grant for 4 cycles, timeout_o pulses, 1 IDLE cycle, then re-grant of 0; the pattern repeats.
- All 7 requests held high forever -> grants rotate 0,1,2,...,6,0, each lasting 16 cycles, and timeout_o pulses on every handover.
- arstn_i pulled low mid-cycle during a grant -> gnt_o=0 immediately without a clock; after release with req_i=7'b1000001 -> gnt_id_o=0.
- Release and timeout on the same edge with req_i[3] also pending -> gnt_id_o=3 and timeout_o=0.
